// File: rtl/fp16_encode_seq.sv
// Sequential FP16 packer: normalizes the extended mantissa one bit per cycle,
// rounds on guard/round/sticky and emits {sign,exp,frac} with overflow/inexact flags.
module fp16_encode_seq #(
  parameter int ROUND_MODE = 0,
  parameter int SAT_INF    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        IN_SIGN_HALF,
  input  logic [4:0]  IN_EXP_HALF,
  input  logic [14:0] IN_MANT_SUM,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] Q,
  output logic        OUT_OVF,
  output logic        OUT_INEXACT
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_nx;
  logic        sign_r, big_r;
  logic [5:0]  exp_r, exp_nx;
  logic [14:0] mant_r, mant_nx;
  logic        cap, ld_out;

  logic        rnd_inc;
  logic [14:0] sum;
  logic [14:0] mant_rnd;
  logic [5:0]  exp_rnd;
  logic [15:0] q_nx;
  logic        ovf_nx, inex_nx;

  assign IN_READY = (state == IDLE) && !RST;

  always_comb begin
    state_nx = state;
    exp_nx   = exp_r;
    mant_nx  = mant_r;
    cap      = 1'b0;
    ld_out   = 1'b0;
    case (state)
      IDLE: begin
        if (IN_VALID && IN_READY) begin
          cap      = 1'b1;
          exp_nx   = {1'b0, IN_EXP_HALF};
          mant_nx  = IN_MANT_SUM;
          state_nx = NORM;
        end
      end
      NORM: begin
        if (big_r || mant_r == 15'd0) begin
          state_nx = ROUND;
        end else if (mant_r[14]) begin
          // shifted-out bit stays folded into sticky
          mant_nx = {1'b0, mant_r[14:1]} | {14'd0, mant_r[0]};
          exp_nx  = exp_r + 6'd1;
        end else if (!mant_r[13] && exp_r > 6'd1) begin
          mant_nx = {mant_r[13:0], 1'b0};
          exp_nx  = exp_r - 6'd1;
        end else begin
          state_nx = ROUND;
        end
      end
      ROUND: begin
        ld_out   = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        if (OUT_READY) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rnd_inc  = (ROUND_MODE == 0) && mant_r[2] && (mant_r[1] || mant_r[0] || mant_r[3]);
    sum      = mant_r + (rnd_inc ? 15'd8 : 15'd0);
    mant_rnd = sum;
    exp_rnd  = exp_r;
    if (sum[14]) begin
      mant_rnd = {1'b0, sum[14:1]};
      exp_rnd  = exp_r + 6'd1;
    end
    q_nx    = {sign_r, (mant_rnd[13] ? exp_rnd[4:0] : 5'd0), mant_rnd[12:3]};
    ovf_nx  = 1'b0;
    inex_nx = |mant_r[2:0];
    if (big_r || exp_rnd >= 6'd31) begin
      q_nx    = (SAT_INF != 0) ? {sign_r, 5'h1F, 10'h000} : {sign_r, 5'h1E, 10'h3FF};
      ovf_nx  = 1'b1;
      inex_nx = 1'b1;
    end else if (mant_r == 15'd0) begin
      q_nx    = {sign_r, 15'd0};
      inex_nx = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      sign_r      <= 1'b0;
      big_r       <= 1'b0;
      exp_r       <= 6'd0;
      mant_r      <= 15'd0;
      Q           <= 16'd0;
      OUT_VALID   <= 1'b0;
      OUT_OVF     <= 1'b0;
      OUT_INEXACT <= 1'b0;
    end else begin
      state  <= state_nx;
      exp_r  <= exp_nx;
      mant_r <= mant_nx;
      if (cap) begin
        sign_r <= IN_SIGN_HALF;
        big_r  <= (IN_EXP_HALF == 5'd31);
      end
      if (ld_out) begin
        Q           <= q_nx;
        OUT_OVF     <= ovf_nx;
        OUT_INEXACT <= inex_nx;
        OUT_VALID   <= 1'b1;
      end else if (state == DONE && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp16_encode_seq.sv
// Bench for fp16_encode_seq: directed spec vectors plus random operands against an arithmetic model,
// run on a default instance and a truncate/max-finite instance side by side.
module tb_fp16_encode_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_SIGN_HALF;
  logic [4:0]  IN_EXP_HALF;
  logic [14:0] IN_MANT_SUM;
  logic        OUT_READY;
  logic        in_ready_a, out_valid_a, ovf_a, inex_a;
  logic        in_ready_b, out_valid_b, ovf_b, inex_b;
  logic [15:0] q_a, q_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  fp16_encode_seq #(.ROUND_MODE(0), .SAT_INF(1)) dut_a (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready_a),
    .IN_SIGN_HALF(IN_SIGN_HALF), .IN_EXP_HALF(IN_EXP_HALF), .IN_MANT_SUM(IN_MANT_SUM),
    .OUT_VALID(out_valid_a), .OUT_READY(OUT_READY), .Q(q_a),
    .OUT_OVF(ovf_a), .OUT_INEXACT(inex_a)
  );

  fp16_encode_seq #(.ROUND_MODE(1), .SAT_INF(0)) dut_b (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready_b),
    .IN_SIGN_HALF(IN_SIGN_HALF), .IN_EXP_HALF(IN_EXP_HALF), .IN_MANT_SUM(IN_MANT_SUM),
    .OUT_VALID(out_valid_b), .OUT_READY(OUT_READY), .Q(q_b),
    .OUT_OVF(ovf_b), .OUT_INEXACT(inex_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value model: mantissa is an integer scaled by 2^-13, normalize by MSB position,
  // round by comparing the 3 dropped bits against half an ulp.
  task automatic model(input logic s, input int e, input int m, input int mode, input int sat,
                       output logic [15:0] q, output logic ovf, output logic inex, output int lat);
    int p, k, mm, ee, keep, rem;
    logic [4:0] ef;
    logic [9:0] ff;
    lat = 0;
    if (e == 31) begin
      q = sat ? {s, 15'h7C00} : {s, 15'h7BFF};
      ovf = 1'b1; inex = 1'b1;
      return;
    end
    if (m == 0) begin
      q = {s, 15'd0}; ovf = 1'b0; inex = 1'b0;
      return;
    end
    p = 0;
    for (int i = 0; i < 15; i++) if (((m >> i) & 1) == 1) p = i;
    if (p == 14) begin
      mm = (m >> 1) | (m & 1); ee = e + 1; lat = 1;
    end else begin
      k = 13 - p;
      if (k > e - 1) k = e - 1;
      mm = m << k; ee = e - k; lat = k;
    end
    keep = mm >> 3;
    rem  = mm & 7;
    if (mode == 0 && (rem > 4 || (rem == 4 && (keep % 2) == 1))) keep = keep + 1;
    if (keep >= 2048) begin
      keep = keep >> 1; ee = ee + 1;
    end
    if (ee >= 31) begin
      q = sat ? {s, 15'h7C00} : {s, 15'h7BFF};
      ovf = 1'b1; inex = 1'b1;
    end else begin
      ef = (keep >= 1024) ? 5'(ee) : 5'd0;
      ff = 10'(keep);
      q = {s, ef, ff};
      ovf = 1'b0; inex = (rem != 0);
    end
  endtask

  task automatic run_op(input logic s, input int e, input int m, input int hold,
                        output logic [15:0] ga, output logic [15:0] gb);
    logic [15:0] qa_m, qb_m, qs;
    logic oa_m, ia_m, ob_m, ib_m;
    int lat, latb, cyc;
    model(s, e, m, 0, 1, qa_m, oa_m, ia_m, lat);
    model(s, e, m, 1, 0, qb_m, ob_m, ib_m, latb);
    cyc = 0;
    @(negedge CLK);
    while (!in_ready_a && cyc < 40) begin
      @(negedge CLK); cyc++;
    end
    check("in_ready_idle", {31'd0, in_ready_a}, 32'd1);
    IN_SIGN_HALF = s; IN_EXP_HALF = 5'(e); IN_MANT_SUM = 15'(m); IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    cyc = 0;
    while (!out_valid_a && cyc < 40) begin
      @(posedge CLK); #1; cyc++;
    end
    check("latency", cyc, 32'(2 + lat));
    check("q_rne_inf", {16'd0, q_a}, {16'd0, qa_m});
    check("flags_rne_inf", {30'd0, ovf_a, inex_a}, {30'd0, oa_m, ia_m});
    check("valid_trunc", {31'd0, out_valid_b}, 32'd1);
    check("q_trunc_max", {16'd0, q_b}, {16'd0, qb_m});
    check("flags_trunc_max", {30'd0, ovf_b, inex_b}, {30'd0, ob_m, ib_m});
    check("in_ready_busy", {31'd0, in_ready_a}, 32'd0);
    ga = q_a; gb = q_b;
    qs = q_a;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check("hold_q", {16'd0, q_a}, {16'd0, qs});
      check("hold_valid", {30'd0, out_valid_a, in_ready_a}, 32'd2);
    end
    @(negedge CLK); OUT_READY = 1'b1;
    @(posedge CLK); #1; OUT_READY = 1'b0;
    check("valid_cleared", {30'd0, out_valid_a, out_valid_b}, 32'd0);
    check("in_ready_back", {31'd0, in_ready_a}, 32'd1);
  endtask

  int          d_e   [6] = '{15, 15, 15, 15, 2, 30};
  int          d_m   [6] = '{'h4000, 'h200C, 'h2004, 'h0008, 'h0800, 'h4000};
  logic [15:0] d_qa  [6] = '{16'h4000, 16'h3C02, 16'h3C00, 16'h1400, 16'h0200, 16'h7C00};
  logic [15:0] d_qb  [6] = '{16'h4000, 16'h3C01, 16'h3C00, 16'h1400, 16'h0200, 16'h7BFF};

  initial begin
    logic [15:0] ga, gb;
    int e, m;
    RST = 1'b1; IN_VALID = 1'b0; IN_SIGN_HALF = 1'b0; IN_EXP_HALF = 5'd0;
    IN_MANT_SUM = 15'd0; OUT_READY = 1'b0;
    #12;
    check("rst_q", {16'd0, q_a}, 32'd0);
    check("rst_outs", {28'd0, out_valid_a, ovf_a, inex_a, in_ready_a}, 32'd0);
    @(negedge CLK); RST = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, d_e[i], d_m[i], (i == 0) ? 5 : 1, ga, gb);
      check($sformatf("dir%0d_qa", i), {16'd0, ga}, {16'd0, d_qa[i]});
      check($sformatf("dir%0d_qb", i), {16'd0, gb}, {16'd0, d_qb[i]});
    end

    for (int n = 0; n < 250; n++) begin
      e = (n % 17 == 0) ? 31 : $urandom_range(1, 30);
      m = $urandom_range(0, 32767) >> $urandom_range(0, 14);
      if (e == 31 && m == 0) m = 1;
      run_op(1'($urandom_range(0, 1)), e, m, $urandom_range(0, 2), ga, gb);
    end

    // reset in the middle of a long left-normalize
    @(negedge CLK);
    IN_SIGN_HALF = 1'b1; IN_EXP_HALF = 5'd15; IN_MANT_SUM = 15'h0008; IN_VALID = 1'b1;
    @(posedge CLK); #1; IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1'b1; #1;
    check("mid_rst_outs", {q_a, 12'd0, out_valid_a, ovf_a, inex_a, in_ready_a}, 32'd0);
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      check("no_valid_after_abort", {31'd0, out_valid_a}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
